card_dealer: RTL

//  Upstream stage of the baccarat datapath. Generates pseudo-random card ranks (1..MAX_RANK)

---
 rtl/card_dealer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
//   Upstream stage of the baccarat datapath. A free-running rank counter
//   (1..MAX_RANK) supplies pseudo-random card ranks. The game FSM picks a hand
//   slot with slot_sel and raises deal_req; the dealer latches the slot, writes
//   the current rank into it if the slot is legal and empty, then answers with
//   deal_ack (plus deal_err when nothing was written) until deal_req falls.
//
//   Optional feature: define CARD_SHUFFLE_EN to step the rank counter by +5
//   modulo MAX_RANK instead of +1 (sequence 1,6,11,3,8,... for MAX_RANK=13).
//
// Ports
//   clock        in   1  system clock, all state on posedge
//   reset        in   1  asynchronous active-high reset
//   deal_req     in   1  level request, held until deal_ack (4-phase)
//   slot_sel     in   3  0..2 = pcard1..3, 3..5 = dcard1..3, 6/7 illegal
//   clear_hand   in   1  synchronous clear of all slots and cards_dealt
//   deal_ack     out  1  high while answering a request
//   deal_err     out  1  with deal_ack: 1 = nothing was written
//   pcard1..3    out  4  player slots (0 = empty)
//   dcard1..3    out  4  dealer slots (0 = empty)
//   cards_dealt  out  3  successful writes since reset/clear (0..6)
// -----------------------------------------------------------------------------
module card_dealer #(
   parameter int MAX_RANK = 13
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       deal_req,
   input  logic [2:0] slot_sel,
   input  logic       clear_hand,
   output logic       deal_ack,
   output logic       deal_err,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic [2:0] cards_dealt
);

   localparam logic [4:0] MAX_R = 5'(MAX_RANK);

   typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

   state_t          state, nstate;
   logic [3:0]      rank;
   logic [2:0]      sel_q;
   logic [5:0][3:0] slot;
   logic            slot_empty;

   // Next rank: always stays within 1..MAX_RANK, never 0.
   function automatic logic [3:0] next_rank(input logic [3:0] r);
      logic [4:0] sum;
`ifdef CARD_SHUFFLE_EN
      sum = {1'b0, r} + 5'd5;
      if (sum > MAX_R) sum = sum - MAX_R;
`else
      if ({1'b0, r} == MAX_R) sum = 5'd1;
      else                    sum = {1'b0, r} + 5'd1;
`endif
      return sum[3:0];
   endfunction

   // Registered slot is writable only when legal (0..5) and currently empty;
   // illegal selects 6/7 never match and so report "not empty".
   always_comb begin
      slot_empty = 1'b0;
      for (int i = 0; i < 6; i++)
         if (sel_q == 3'(i)) slot_empty = (slot[i] == 4'd0);
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // Next-state logic
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (deal_req) nstate = CAPTURE;
         CAPTURE: nstate = ACK;
         ACK:     if (!deal_req) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      deal_ack = (state == ACK);
   end

   // Rank counter, slot capture, hand contents and error flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rank        <= 4'd1;
         sel_q       <= 3'd0;
         slot        <= '0;
         cards_dealt <= 3'd0;
         deal_err    <= 1'b0;
      end else begin
         rank <= next_rank(rank);

         if (state == IDLE && deal_req) sel_q <= slot_sel;

         if (state == CAPTURE)                deal_err <= !slot_empty;
         else if (state == ACK && !deal_req)  deal_err <= 1'b0;

         // A coincident clear wins over the capture write.
         if (clear_hand) begin
            slot        <= '0;
            cards_dealt <= 3'd0;
         end else if (state == CAPTURE && slot_empty) begin
            for (int i = 0; i < 6; i++)
               if (sel_q == 3'(i)) slot[i] <= rank;
            if (cards_dealt != 3'd6) cards_dealt <= cards_dealt + 3'd1;
         end
      end
   end

   assign pcard1 = slot[0];
   assign pcard2 = slot[1];
   assign pcard3 = slot[2];
   assign dcard1 = slot[3];
   assign dcard2 = slot[4];
   assign dcard3 = slot[5];

endmodule
